hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage stall-only hazard unit.
- Tracks in-flight register writes in a shift-register scoreboard, one entry per post-issue stage.
- Per source operand it decides either stall (result not yet produced) or forward, and names the stage to forward from. It also supports issue-slot flush and a saturating stall performance counter.
- Sits beside the decode/issue stage. It drives the decode-register hold, the EX bubble insert and the operand forwarding muxes.

---
 rtl/hazard_scoreboard_pkg.sv | 22 ++
 rtl/hazard_src_lookup.sv | 33 +++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and the scoreboard entry type for the decode-stage hazard unit.
// Entry fields are sized for the largest supported configuration; unused upper bits stay zero.
package hazard_scoreboard_pkg;

  localparam int SB_DST_W = 16;
  localparam int SB_LAT_W = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  typedef struct packed {
    logic                valid;
    logic [SB_DST_W-1:0] dst;
    logic [SB_LAT_W-1:0] lat;
  } sb_entry_t;

endpackage

// File: rtl/hazard_src_lookup.sv
// Youngest-match search over the scoreboard for one source operand.
// Produces a hazard flag, or the stage to forward from when the value already exists.
module hazard_src_lookup
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES         = 3,
  parameter int RW             = 5,
  parameter int SW             = 2,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  sb_entry_t [STAGES:1] i_entries,
  input  logic [RW-1:0]        i_src,
  input  logic                 i_re,
  output logic                 o_hazard,
  output logic [SW-1:0]        o_fwd
);

  logic src_ok;

  always_comb begin
    src_ok   = i_re && !(ZERO_HARDWIRED && (i_src == '0));
    o_hazard = 1'b0;
    o_fwd    = SW'(FWD_RF);
    // Scan oldest to youngest so the lowest matching stage has the final say.
    for (int k = STAGES; k >= 1; k--) begin
      if (src_ok && i_entries[k].valid && (i_entries[k].dst == SB_DST_W'(i_src))) begin
        o_hazard = (SB_LAT_W'(k) < i_entries[k].lat);
        o_fwd    = o_hazard ? SW'(FWD_RF) : SW'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: shift-register scoreboard of in-flight writes driving
// stall, EX bubble insert and per-operand forwarding selects, plus a stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG           = 32,
  parameter int STAGES         = 3,
  parameter bit ZERO_HARDWIRED = 1'b1,
  parameter int CNT_W          = 16,
  localparam int RW            = $clog2(NREG),
  localparam int SW            = $clog2(STAGES + 1),
  localparam int LW            = $clog2(STAGES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue_valid,
  input  logic [RW-1:0]    i_rs,
  input  logic             i_rs_re,
  input  logic [RW-1:0]    i_rt,
  input  logic             i_rt_re,
  input  logic [RW-1:0]    i_dst,
  input  logic             i_dst_we,
  input  logic [LW-1:0]    i_dst_lat,
  input  logic             i_flush,
  output logic             o_stall,
  output logic             o_we_dec,
  output logic             o_s_rst_ex,
  output logic [SW-1:0]    o_fwd_rs,
  output logic [SW-1:0]    o_fwd_rt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Issue handshake: an instruction presented with i_issue_valid is accepted on the
  // rising edge unless o_stall or i_flush is high in that same cycle; stages past
  // issue never stall, so the scoreboard shifts unconditionally every edge.

  sb_entry_t [STAGES:1] entry_q, entry_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                 hz_rs, hz_rt;
  logic [SW-1:0]        fwd_rs, fwd_rt;
  logic [LW-1:0]        lat_norm;
  logic                 stall;

  hazard_src_lookup #(
    .STAGES         (STAGES),
    .RW             (RW),
    .SW             (SW),
    .ZERO_HARDWIRED (ZERO_HARDWIRED)
  ) u_lookup_rs (
    .i_entries (entry_q),
    .i_src     (i_rs),
    .i_re      (i_rs_re),
    .o_hazard  (hz_rs),
    .o_fwd     (fwd_rs)
  );

  hazard_src_lookup #(
    .STAGES         (STAGES),
    .RW             (RW),
    .SW             (SW),
    .ZERO_HARDWIRED (ZERO_HARDWIRED)
  ) u_lookup_rt (
    .i_entries (entry_q),
    .i_src     (i_rt),
    .i_re      (i_rt_re),
    .o_hazard  (hz_rt),
    .o_fwd     (fwd_rt)
  );

  always_comb begin
    if (i_dst_lat == '0) begin
      lat_norm = LW'(LAT_ALU);
    end else if (i_dst_lat > LW'(STAGES)) begin
      lat_norm = LW'(STAGES);
    end else begin
      lat_norm = i_dst_lat;
    end

    stall = i_issue_valid & ~i_flush & (hz_rs | hz_rt);

    // A stalled or flushed slot enters the pipe as an invalid entry: the bubble.
    entry_d[1].valid = i_issue_valid & ~stall & ~i_flush & i_dst_we
                       & ~(ZERO_HARDWIRED && (i_dst == '0));
    entry_d[1].dst   = SB_DST_W'(i_dst);
    entry_d[1].lat   = SB_LAT_W'(lat_norm);
    for (int k = 1; k < STAGES; k++) begin
      entry_d[k+1] = entry_q[k];
    end

    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      entry_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall     = stall;
  assign o_we_dec    = stall;
  assign o_s_rst_ex  = stall | i_flush;
  assign o_fwd_rs    = fwd_rs;
  assign o_fwd_rt    = fwd_rt;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a timestamp-based model
// of in-flight writes; expectations are queued by the driver and checked by a monitor.
module tb_hazard_scoreboard;

  localparam int NREG   = 32;
  localparam int STAGES = 3;
  localparam int CNT_W  = 12;  // narrower counter so saturation is reachable in a short run
  localparam int RW     = $clog2(NREG);
  localparam int SW     = $clog2(STAGES + 1);
  localparam int LW     = $clog2(STAGES + 1);
  localparam int EW     = 3 + 2 * SW + CNT_W;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic [RW-1:0]    rs, rt, dst;
  logic             rs_re, rt_re, dst_we, flush;
  logic [LW-1:0]    dst_lat;
  logic             stall, we_dec, s_rst_ex;
  logic [SW-1:0]    fwd_rs, fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  hazard_scoreboard #(
    .NREG           (NREG),
    .STAGES         (STAGES),
    .ZERO_HARDWIRED (1'b1),
    .CNT_W          (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_issue_valid (issue_valid),
    .i_rs          (rs),
    .i_rs_re       (rs_re),
    .i_rt          (rt),
    .i_rt_re       (rt_re),
    .i_dst         (dst),
    .i_dst_we      (dst_we),
    .i_dst_lat     (dst_lat),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_we_dec      (we_dec),
    .o_s_rst_ex    (s_rst_ex),
    .o_fwd_rs      (fwd_rs),
    .o_fwd_rt      (fwd_rt),
    .o_stall_cnt   (stall_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Each accepted writer is remembered with its issue cycle; its stage is simply
  // the number of cycles elapsed since issue.
  typedef struct {
    int dst;
    int lat;
    int t;
  } wr_t;

  wr_t inflight[$];
  int  now;
  int  m_cnt;

  function automatic void src_eval(input int s, input bit re, output bit hz, output int fwd);
    int best_t, best_age, best_lat;
    best_t = -1; best_age = 0; best_lat = 0;
    hz = 1'b0; fwd = 0;
    if (!re || s == 0) return;
    foreach (inflight[i]) begin
      int age;
      age = now - inflight[i].t;
      if (inflight[i].dst == s && age >= 1 && age <= STAGES && inflight[i].t > best_t) begin
        best_t   = inflight[i].t;
        best_age = age;
        best_lat = inflight[i].lat;
      end
    end
    if (best_t >= 0) begin
      if (best_age >= best_lat) fwd = best_age;
      else hz = 1'b1;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_cmp;
  int            n_err;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {stall, we_dec, s_rst_ex, fwd_rs, fwd_rt, stall_cnt};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s @%0t: got stall=%b we_dec=%b s_rst_ex=%b fwd_rs=%0d fwd_rt=%0d cnt=%0d, expected stall=%b we_dec=%b s_rst_ex=%b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                 nm, $time, got[EW-1], got[EW-2], got[EW-3], got[2*SW+CNT_W-1 -: SW],
                 got[SW+CNT_W-1 -: SW], got[CNT_W-1:0], e[EW-1], e[EW-2], e[EW-3],
                 e[2*SW+CNT_W-1 -: SW], e[SW+CNT_W-1 -: SW], e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    issue_valid = 1'b0;
    rs = '0; rs_re = 1'b0; rt = '0; rt_re = 1'b0;
    dst = '0; dst_we = 1'b0; dst_lat = '0; flush = 1'b0;
  endtask

  // One issue cycle. With has_exp the stall/forward expectation is the hand-derived
  // constant given; otherwise it comes from the model. The counter always comes from the model.
  task automatic step(input bit v, input int s_rs, input bit s_rs_re, input int s_rt,
                      input bit s_rt_re, input int s_dst, input bit s_we, input int s_lat,
                      input bit fl, input bit has_exp, input bit e_stall, input int e_rs,
                      input int e_rt, input string nm);
    bit h_rs, h_rt, st;
    int f_rs, f_rt, nl;
    @(posedge clk);
    #1;
    issue_valid = v;
    rs = RW'(s_rs); rs_re = s_rs_re; rt = RW'(s_rt); rt_re = s_rt_re;
    dst = RW'(s_dst); dst_we = s_we; dst_lat = LW'(s_lat); flush = fl;

    src_eval(s_rs, s_rs_re, h_rs, f_rs);
    src_eval(s_rt, s_rt_re, h_rt, f_rt);
    st = v && !fl && (h_rs || h_rt);
    if (has_exp) begin
      exp_q.push_back({e_stall, e_stall, e_stall | fl, SW'(e_rs), SW'(e_rt), CNT_W'(m_cnt)});
    end else begin
      exp_q.push_back({st, st, st | fl, SW'(f_rs), SW'(f_rt), CNT_W'(m_cnt)});
    end
    name_q.push_back(nm);

    if (st && m_cnt < MAXC) m_cnt++;
    nl = (s_lat == 0) ? 1 : ((s_lat > STAGES) ? STAGES : s_lat);
    if (v && !st && !fl && s_we && s_dst != 0) inflight.push_back('{s_dst, nl, now});
    now++;
    while (inflight.size() > 0 && (now - inflight[0].t) > STAGES) void'(inflight.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  // Raises reset part-way through the current cycle, leaving the other inputs as they
  // are, and expects every output to have dropped before the next clock edge.
  task automatic reset_check(input bit fl, input string nm);
    @(posedge clk);
    #2;
    flush = fl;
    rst   = 1'b1;
    exp_q.push_back({1'b0, 1'b0, fl, SW'(0), SW'(0), CNT_W'(0)});
    name_q.push_back(nm);
    inflight.delete();
    m_cnt = 0;
    @(negedge clk);
    #1;
    drive_idle();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    n_cmp = 0; n_err = 0; now = 0; m_cnt = 0;
    rst = 1'b1;
    drive_idle();

    reset_check(1'b1, "reset_outputs");

    // ALU producer then dependent: forward from EX, no stall
    step(1, 1, 1, 2, 1, 3, 1, 1, 0, 1, 0, 0, 0, "add_r3");
    step(1, 3, 1, 2, 1, 8, 1, 1, 0, 1, 0, 1, 0, "sub_uses_r3");
    idle(3);

    // load-use: one stall cycle, then forward from MEM
    step(1, 0, 0, 0, 0, 5, 1, 2, 0, 1, 0, 0, 0, "lw_r5");
    step(1, 5, 1, 0, 0, 6, 1, 1, 0, 1, 1, 0, 0, "load_use_stall");
    step(1, 5, 1, 0, 0, 6, 1, 1, 0, 1, 0, 2, 0, "load_use_fwd");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "cnt_after_load_use");
    idle(3);

    // youngest match wins
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, "add_r4");
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, "or_r4");
    step(1, 0, 0, 4, 1, 9, 1, 1, 0, 1, 0, 0, 1, "youngest_rt");
    idle(3);
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, 1, 0, 0, 0, "add_r4_again");
    idle(3);
    step(1, 0, 0, 4, 1, 9, 1, 1, 0, 1, 0, 0, 0, "retired_rt");

    // r0 never hazards or forwards
    step(1, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, "write_r0");
    step(1, 0, 1, 0, 1, 11, 1, 1, 0, 1, 0, 0, 0, "read_r0");
    idle(3);

    // flush overrides stall and leaves no entry behind
    step(1, 0, 0, 0, 0, 7, 1, 2, 0, 1, 0, 0, 0, "lw_r7");
    step(1, 7, 1, 0, 0, 7, 1, 1, 1, 1, 0, 0, 0, "flushed_reader");
    step(1, 7, 1, 0, 0, 12, 1, 1, 0, 1, 0, 2, 0, "after_flush");
    idle(3);

    // rs == rt share the same select; lat 0 behaves as ALU
    step(1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0, 0, "alu_r10_lat0");
    step(1, 10, 1, 10, 1, 13, 1, 1, 0, 1, 0, 1, 1, "rs_eq_rt");
    idle(3);

    // randomised traffic on a small register window
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 9) == 0,
           0, 0, 0, 0, "random");
    end
    idle(3);

    // self-dependent lat-3 chain: stalls two of every three cycles until the counter saturates
    for (int i = 0; i < 6300; i++) begin
      step(1, 1, 1, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0, "saturate");
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "saturated_cnt");
    idle(3);

    // reset while a stall is in progress
    step(1, 0, 0, 0, 0, 9, 1, 3, 0, 1, 0, 0, 0, "lw_r9_lat3");
    step(1, 9, 1, 0, 0, 14, 1, 1, 0, 1, 1, 0, 0, "stall_before_reset");
    reset_check(1'b1, "reset_mid_stall");
    step(1, 9, 1, 0, 0, 14, 1, 1, 0, 1, 0, 0, 0, "after_reset_no_stall");
    idle(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
